q_update_writer: RTL and testbench

//  Q-learning write-back engine for the tic-tac-toe agent. Consumes the 18-bit max-Q produced by the
//  9-way max reducer, reads Q(s,a) from the Q-table, computes Q += alpha*(r + gamma*maxQ - Q) and writes
//  it back. Sits between the agent controller (start/done) and the Q-table RAM port (req/valid, wr/ack).

---
 rtl/q_update_writer.sv | 166 ++++++++++++++++
 tb/tb_q_update_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/q_update_writer.sv
// rtl/q_update_writer.sv - Q-learning write-back engine: read Q(s,a), apply TD update, write back
//
// Purpose: on start_i, reads Q(s,a) from the Q-table, computes
//   Q += alpha * (r + gamma*maxQ - Q) using shift-based alpha and gamma,
//   clamps the result to [0, 2^Q_W-1], and writes it back.
//   FSM: IDLE -> READ -> CALC -> WRITE -> DONE -> IDLE.
//
// Optional feature macro: Q_UPDATE_STATS_EN (adds upd_cnt_o / sat_cnt_o counters).
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start_i, addr_i, reward_i,      update request and its operands
//   max_q_i, terminal_i             (latched in IDLE)
//   busy_o, done_o                  status to the agent controller
//   mem_rd_req_o, mem_addr_o,       Q-table read port (req held until valid)
//   mem_rd_valid_i, mem_rd_data_i
//   mem_wr_en_o, mem_wr_data_o,     Q-table write port (strobe held until ack)
//   mem_wr_ack_i
//   upd_cnt_o, sat_cnt_o            update / saturation counters (Q_UPDATE_STATS_EN only)

module q_update_writer #(
    parameter int Q_W         = 18,
    parameter int FRAC_W      = 10,
    parameter int R_W         = 8,
    parameter int ADDR_W      = 15,
    parameter int ALPHA_SHIFT = 3,
    parameter int GAMMA_NUM   = 7,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [R_W-1:0]    reward_i,
    input  logic [Q_W-1:0]    max_q_i,
    input  logic              terminal_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rd_valid_i,
    input  logic [Q_W-1:0]    mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [Q_W-1:0]    mem_wr_data_o,
    input  logic              mem_wr_ack_i
`ifdef Q_UPDATE_STATS_EN
    ,
    output logic [15:0]       upd_cnt_o,
    output logic [15:0]       sat_cnt_o
`endif
);

    // Wide enough for reward<<FRAC_W plus gamma term plus sign and headroom.
    localparam int W = Q_W + R_W + 4;
    localparam logic signed [W-1:0] C_GAMMA = W'(GAMMA_NUM);
    localparam logic signed [W-1:0] C_QMAX  = {{(W-Q_W){1'b0}}, {Q_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [R_W-1:0]    r_reward;
    logic [Q_W-1:0]    r_max_q;
    logic              r_term;
    logic [Q_W-1:0]    r_q_old;
    logic [Q_W-1:0]    r_wr_data;

    logic signed [W-1:0] w_reward_sh;
    logic signed [W-1:0] w_gamma;
    logic signed [W-1:0] w_q_old;
    logic signed [W-1:0] w_target;
    logic signed [W-1:0] w_delta;
    logic signed [W-1:0] w_sum;
    logic [Q_W-1:0]      w_q_new;
    logic                w_sat;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i)        w_next = S_READ;
            S_READ:  if (mem_rd_valid_i) w_next = S_CALC;
            S_CALC:                      w_next = S_WRITE;
            S_WRITE: if (mem_wr_ack_i)   w_next = S_DONE;
            S_DONE:                      w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign mem_rd_req_o  = (r_state == S_READ);
    assign mem_wr_en_o   = (r_state == S_WRITE);
    assign mem_addr_o    = r_addr;
    assign mem_wr_data_o = r_wr_data;

    // ---------------- Update arithmetic ----------------
    assign w_reward_sh = $signed({{(W-R_W){reward_i[R_W-1] & 1'b0 | r_reward[R_W-1]}}, r_reward}) <<< FRAC_W;
    // Gamma term floors because the product is non-negative before the shift.
    assign w_gamma     = r_term ? '0
                       : (($signed({{(W-Q_W){1'b0}}, r_max_q}) * C_GAMMA) >>> GAMMA_SHIFT);
    assign w_q_old     = $signed({{(W-Q_W){1'b0}}, r_q_old});
    assign w_target    = w_reward_sh + w_gamma;
    // Arithmetic shift: negative deltas round toward -inf.
    assign w_delta     = (w_target - w_q_old) >>> ALPHA_SHIFT;
    assign w_sum       = w_q_old + w_delta;

    always_comb begin
        w_q_new = w_sum[Q_W-1:0];
        w_sat   = 1'b0;
        if (w_sum < 0) begin
            w_q_new = '0;
            w_sat   = 1'b1;
        end else if (w_sum > C_QMAX) begin
            w_q_new = {Q_W{1'b1}};
            w_sat   = 1'b1;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_reward  <= '0;
            r_max_q   <= '0;
            r_term    <= 1'b0;
            r_q_old   <= '0;
            r_wr_data <= '0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_addr   <= addr_i;
                r_reward <= reward_i;
                r_max_q  <= max_q_i;
                r_term   <= terminal_i;
            end
            if (r_state == S_READ && mem_rd_valid_i) r_q_old <= mem_rd_data_i;
            if (r_state == S_CALC)                   r_wr_data <= w_q_new;
        end
    end

`ifdef Q_UPDATE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_cnt_o <= '0;
            sat_cnt_o <= '0;
        end else begin
            if (r_state == S_DONE)          upd_cnt_o <= upd_cnt_o + 16'd1;
            if (r_state == S_CALC && w_sat) sat_cnt_o <= sat_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_q_update_writer.sv
// tb/tb_q_update_writer.sv - directed self-checking bench for q_update_writer
module tb_q_update_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [14:0] addr_i;
    logic [7:0]  reward_i;
    logic [17:0] max_q_i;
    logic        terminal_i;
    logic        busy_o;
    logic        done_o;
    logic        mem_rd_req_o;
    logic [14:0] mem_addr_o;
    logic        mem_rd_valid_i;
    logic [17:0] mem_rd_data_i;
    logic        mem_wr_en_o;
    logic [17:0] mem_wr_data_o;
    logic        mem_wr_ack_i;
`ifdef Q_UPDATE_STATS_EN
    logic [15:0] upd_cnt_o;
    logic [15:0] sat_cnt_o;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    q_update_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .addr_i         (addr_i),
        .reward_i       (reward_i),
        .max_q_i        (max_q_i),
        .terminal_i     (terminal_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mem_rd_req_o   (mem_rd_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rd_valid_i (mem_rd_valid_i),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_wr_ack_i   (mem_wr_ack_i)
`ifdef Q_UPDATE_STATS_EN
        ,
        .upd_cnt_o      (upd_cnt_o),
        .sat_cnt_o      (sat_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full update against a bench-side RAM responder. Inputs change on negedges,
    // outputs are sampled on negedges. t counts negedges after start_i was presented.
    task automatic run_update(input string nm, input logic [17:0] q_old, input logic [7:0] rw,
                              input logic [17:0] mq, input logic term, input int rd_dly,
                              input int ack_dly, input logic poke, input logic [17:0] exp_data,
                              input logic [14:0] a);
        int n_req;
        int n_wr;
        int t;
        int guard;
        @(negedge clk);
        start_i = 1'b1; addr_i = a; reward_i = rw; max_q_i = mq; terminal_i = term;
        @(negedge clk);
        t = 1;
        start_i = 1'b0; addr_i = ~a; reward_i = 8'h55; max_q_i = 18'h2AAAA; terminal_i = ~term;
        check_eq({nm, ".rd_req_first"}, {31'd0, mem_rd_req_o}, 32'd1);
        check_eq({nm, ".rd_addr"}, {17'd0, mem_addr_o}, {17'd0, a});
        n_req = 0; guard = 0;
        while (mem_rd_req_o && guard < 64) begin
            n_req++;
            mem_rd_valid_i = (n_req == rd_dly + 1);
            mem_rd_data_i  = (n_req == rd_dly + 1) ? q_old : 18'h15A5A;
            start_i        = poke;
            @(negedge clk);
            t++; guard++;
            mem_rd_valid_i = 1'b0; start_i = 1'b0;
        end
        check_eq({nm, ".rd_req_cycles"}, n_req, rd_dly + 1);
        check_eq({nm, ".calc_busy"}, {30'd0, busy_o, mem_wr_en_o}, 32'd2);
        @(negedge clk);
        t++;
        check_eq({nm, ".wr_data"}, {14'd0, mem_wr_data_o}, {14'd0, exp_data});
        check_eq({nm, ".wr_addr"}, {17'd0, mem_addr_o}, {17'd0, a});
        n_wr = 0; guard = 0;
        while (mem_wr_en_o && guard < 64) begin
            n_wr++;
            mem_wr_ack_i = (n_wr == ack_dly + 1);
            start_i      = poke;
            @(negedge clk);
            t++; guard++;
            mem_wr_ack_i = 1'b0; start_i = 1'b0;
        end
        check_eq({nm, ".wr_en_cycles"}, n_wr, ack_dly + 1);
        check_eq({nm, ".done_busy"}, {30'd0, done_o, busy_o}, 32'd3);
        check_eq({nm, ".done_cycle"}, t, 4 + rd_dly + ack_dly);
        @(negedge clk);
        check_eq({nm, ".after_done"}, {29'd0, done_o, busy_o, mem_rd_req_o}, 32'd0);
        @(negedge clk);
        check_eq({nm, ".still_idle"}, {30'd0, busy_o, mem_wr_en_o}, 32'd0);
    endtask

    initial begin
        int guard;
        rst = 1'b1; start_i = 1'b0; addr_i = '0; reward_i = '0; max_q_i = '0;
        terminal_i = 1'b0; mem_rd_valid_i = 1'b0; mem_rd_data_i = '0; mem_wr_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset.outs", {14'd0, busy_o, done_o, mem_rd_req_o, mem_wr_en_o}, 32'd0);
        check_eq("reset.wr_data", {14'd0, mem_wr_data_o}, 32'd0);
        check_eq("reset.addr", {17'd0, mem_addr_o}, 32'd0);
        rst = 1'b0;
        // Stray handshakes in IDLE must not start anything.
        mem_rd_valid_i = 1'b1; mem_wr_ack_i = 1'b1;
        @(negedge clk);
        mem_rd_valid_i = 1'b0; mem_wr_ack_i = 1'b0;
        check_eq("idle.stray", {30'd0, busy_o, done_o}, 32'd0);

        // 1: target=1024+1792=2816, delta=224 -> 1248
        run_update("t1", 18'd1024, 8'd1, 18'd2048, 1'b0, 0, 0, 1'b0, 18'd1248, 15'h1234);
        // 2: terminal, gamma term dropped -> 1024
        run_update("t2", 18'd1024, 8'd1, 18'h3FFFF, 1'b1, 0, 0, 1'b0, 18'd1024, 15'h0001);
        // 3: target=-1024, delta=-128 -> -128 clamps to 0
        run_update("t3", 18'd0, 8'hFF, 18'd0, 1'b1, 0, 0, 1'b0, 18'd0, 15'h7FFF);
`ifdef Q_UPDATE_STATS_EN
        check_eq("t3.sat_cnt", {16'd0, sat_cnt_o}, 32'd1);
        check_eq("t3.upd_cnt", {16'd0, upd_cnt_o}, 32'd3);
`endif
        // 4: target=130048+229375, delta=12160 -> 274303 clamps to 0x3FFFF
        run_update("t4", 18'h3FFFF, 8'd127, 18'h3FFFF, 1'b0, 0, 0, 1'b0, 18'h3FFFF, 15'h2AAA);
        // 5: delayed handshakes, start_i poked while busy; q_old=2048, r=0, maxQ=1024 ->
        //    target=896, delta=(896-2048)>>>3=-144 -> 1904
        run_update("t5", 18'd2048, 8'd0, 18'd1024, 1'b0, 3, 2, 1'b1, 18'd1904, 15'h0F0F);

        // 6: reset during WRITE
        @(negedge clk);
        start_i = 1'b1; addr_i = 15'h0ABC; reward_i = 8'd1; max_q_i = 18'd2048; terminal_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        mem_rd_valid_i = 1'b1; mem_rd_data_i = 18'd1024;
        guard = 0;
        while (!mem_wr_en_o && guard < 20) begin
            @(negedge clk);
            mem_rd_valid_i = 1'b0;
            guard++;
        end
        mem_rd_valid_i = 1'b0;
        check_eq("t6.in_write", {31'd0, mem_wr_en_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6.rst_outs", {14'd0, busy_o, done_o, mem_rd_req_o, mem_wr_en_o}, 32'd0);
        check_eq("t6.rst_data", {14'd0, mem_wr_data_o}, 32'd0);
        check_eq("t6.rst_addr", {17'd0, mem_addr_o}, 32'd0);
        rst = 1'b0;
        mem_wr_ack_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t6.no_done", {30'd0, done_o, busy_o}, 32'd0);
        end
        mem_wr_ack_i = 1'b0;
        run_update("t6b", 18'd1024, 8'd1, 18'd2048, 1'b0, 1, 0, 1'b0, 18'd1248, 15'h0333);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
